// File: rtl/mio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mio_bus_ctrl
// Brief   : Memory/IO bus bridge decoding MemRead/MemWrite requests to a word
//           RAM or to GPIO / switch / cycle-counter registers.
// Revision: 1.0
// ============================================================================
module mio_bus_ctrl #(
  parameter int          RAM_WAIT = 1,
  parameter int          RAM_AW   = 10,
  parameter logic [15:0] GPIO_RST = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [15:0]       gpio_out,
  input  logic [15:0]       sw_in
);

  localparam logic [31:0] c_GPIO_ADDR = 32'hF000_0000;
  localparam logic [31:0] c_SW_ADDR   = 32'hF000_0004;
  localparam logic [31:0] c_CNT_ADDR  = 32'hF000_0008;
  localparam int          c_WW        = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;
  localparam logic [c_WW-1:0] c_WLAST = c_WW'(RAM_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PERIPH   = 3'd1,
    S_RAM_EN   = 3'd2,
    S_RAM_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_req_q;
  logic              r_pend;
  logic              r_pend_we;
  logic [31:0]       r_pend_addr;
  logic [31:0]       r_pend_wdata;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [c_WW-1:0]   r_wcnt;
  logic [31:0]       r_rdata;
  logic              r_mio_ready;
  logic              r_busy;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic [15:0]       r_gpio;
  logic [31:0]       r_cnt;

  logic        w_req;
  logic        w_rise;
  logic        w_pend_load;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_ram;
  logic        w_cnt_wr;
  logic [31:0] w_periph_rdata;

  assign w_req  = mem_r | mem_w;
  assign w_rise = w_req & ~r_req_q;

  // An edge refills the buffer when busy and empty, or when IDLE is draining it.
  assign w_pend_load = w_rise & (((r_state != S_IDLE) & ~r_pend) |
                                 ((r_state == S_IDLE) &  r_pend));

  assign w_sel_we    = r_pend ? r_pend_we    : mem_w;
  assign w_sel_addr  = r_pend ? r_pend_addr  : addr;
  assign w_sel_wdata = r_pend ? r_pend_wdata : wdata;
  assign w_sel_ram   = (w_sel_addr[31:28] != 4'hF);

  assign w_cnt_wr = (r_state == S_PERIPH) & r_we & (r_addr == c_CNT_ADDR);

  always_comb begin
    w_periph_rdata = 32'h0;
    case (r_addr)
      c_GPIO_ADDR: w_periph_rdata = {16'h0, r_gpio};
      c_SW_ADDR:   w_periph_rdata = {16'h0, sw_in};
      c_CNT_ADDR:  w_periph_rdata = r_cnt;
      default:     w_periph_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 32'h0;
    end else if (w_cnt_wr) begin
      r_cnt <= r_wdata;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_req_q      <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= 32'h0;
      r_pend_wdata <= 32'h0;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_wcnt       <= '0;
      r_rdata      <= 32'h0;
      r_mio_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= 32'h0;
      r_gpio       <= GPIO_RST;
    end else begin
      r_req_q     <= w_req;
      r_mio_ready <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;

      if (w_pend_load) begin
        r_pend       <= 1'b1;
        r_pend_we    <= mem_w;
        r_pend_addr  <= addr;
        r_pend_wdata <= wdata;
      end else if ((r_state == S_IDLE) && r_pend) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend || w_rise) begin
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_busy  <= 1'b1;
            if (w_sel_ram) begin
              r_ram_en    <= 1'b1;
              r_ram_we    <= w_sel_we;
              r_ram_addr  <= w_sel_addr[RAM_AW+1:2];
              r_ram_wdata <= w_sel_wdata;
              r_state     <= S_RAM_EN;
            end else begin
              r_state <= S_PERIPH;
            end
          end
        end
        S_PERIPH: begin
          if (!r_we) begin
            r_rdata <= w_periph_rdata;
          end else if (r_addr == c_GPIO_ADDR) begin
            r_gpio <= r_wdata[15:0];
          end
          r_mio_ready <= 1'b1;
          r_state     <= S_DONE;
        end
        S_RAM_EN: begin
          r_wcnt  <= '0;
          r_state <= S_RAM_WAIT;
        end
        S_RAM_WAIT: begin
          if (r_wcnt == c_WLAST) begin
            if (!r_we) begin
              r_rdata <= ram_rdata;
            end
            r_mio_ready <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt + c_WW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign mio_ready = r_mio_ready;
  assign busy      = r_busy;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign gpio_out  = r_gpio;

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mio_bus_ctrl
// Brief   : Self-checking bench for mio_bus_ctrl against a timing/transaction
//           model, with directed scenarios followed by randomized traffic.
// Revision: 1.0
// ============================================================================
module tb_mio_bus_ctrl;

  localparam int          RW   = 2;
  localparam int          AW   = 10;
  localparam logic [15:0] GRST = 16'hA5C3;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_r, mem_w;
  logic [31:0]   addr, wdata;
  logic [31:0]   rdata;
  logic          mio_ready, busy, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [15:0]   gpio_out, sw_in;

  mio_bus_ctrl #(.RAM_WAIT(RW), .RAM_AW(AW), .GPIO_RST(GRST)) dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .gpio_out(gpio_out),
    .sw_in(sw_in)
  );

  always #5 clk = ~clk;

  // External synchronous RAM seen by the DUT.
  logic [31:0] ram_mem [0:(1<<AW)-1];
  bit          ram_inited = 1'b0;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= 32'h0;
      ram_rdata  <= 32'h0;
      ram_inited <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int ready_seen = 0;

  // Transaction model: each accepted access is described by its accept edge
  // and finish edge; outputs follow from edge arithmetic.
  int          e = 0;
  int          free_edge = 0;
  bit          req_prev;
  bit          have_txn, t_we, t_ram;
  int          t_acc, t_fin;
  logic [31:0] t_addr, t_wdata;
  bit          pend_v, p_we;
  logic [31:0] p_addr, p_wdata;
  logic [31:0] m_cnt, m_rdata;
  logic [15:0] m_gpio;
  logic [31:0] shadow [0:(1<<AW)-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic [31:0] periph_val(input logic [31:0] a);
    if (a == 32'hF000_0000) return {16'h0, m_gpio};
    if (a == 32'hF000_0004) return {16'h0, sw_in};
    if (a == 32'hF000_0008) return m_cnt;
    return 32'h0;
  endfunction

  task automatic model_reset();
    req_prev = 1'b0; have_txn = 1'b0; pend_v = 1'b0; free_edge = 0;
    m_cnt = 32'h0; m_rdata = 32'h0; m_gpio = GRST;
  endtask

  task automatic model_step();
    bit          rise;
    logic [31:0] cnt_next;
    e++;
    rise = (mem_r | mem_w) && !req_prev;
    req_prev = mem_r | mem_w;
    cnt_next = m_cnt + 32'd1;
    if (have_txn) begin
      if (t_ram && t_we && e == t_acc + 1) shadow[widx(t_addr)] = t_wdata;
      if (e == t_fin) begin
        if (!t_ram) begin
          if (t_we) begin
            if (t_addr == 32'hF000_0000) m_gpio = t_wdata[15:0];
            else if (t_addr == 32'hF000_0008) cnt_next = t_wdata;
          end else begin
            m_rdata = periph_val(t_addr);
          end
        end else if (!t_we) begin
          m_rdata = shadow[widx(t_addr)];
        end
      end
    end
    m_cnt = cnt_next;
    if (e >= free_edge && (pend_v || rise)) begin
      if (pend_v) begin
        t_we = p_we; t_addr = p_addr; t_wdata = p_wdata;
        pend_v = rise;
        if (rise) begin p_we = mem_w; p_addr = addr; p_wdata = wdata; end
      end else begin
        t_we = mem_w; t_addr = addr; t_wdata = wdata;
      end
      have_txn = 1'b1;
      t_ram = (t_addr[31:28] != 4'hF);
      t_acc = e;
      t_fin = t_ram ? e + 1 + RW : e + 1;
      free_edge = t_fin + 2;
    end else if (e < free_edge && rise && !pend_v) begin
      pend_v = 1'b1; p_we = mem_w; p_addr = addr; p_wdata = wdata;
    end
  endtask

  task automatic compare();
    bit exp_en;
    exp_en = have_txn && t_ram && (e == t_acc);
    chk("busy",      {31'h0, busy},      {31'h0, have_txn && (e <= t_fin)});
    chk("mio_ready", {31'h0, mio_ready}, {31'h0, have_txn && (e == t_fin)});
    chk("ram_en",    {31'h0, ram_en},    {31'h0, exp_en});
    chk("ram_we",    {31'h0, ram_we},    {31'h0, exp_en && t_we});
    chk("gpio_out",  {16'h0, gpio_out},  {16'h0, m_gpio});
    chk("rdata",     rdata,              m_rdata);
    if (exp_en) begin
      chk("ram_addr", {22'h0, ram_addr}, {22'h0, t_addr[AW+1:2]});
      if (t_we) chk("ram_wdata", ram_wdata, t_wdata);
    end
    if (mio_ready) ready_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    mem_r = r; mem_w = w; addr = a; wdata = d;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = 32'hF000_0000;
      1: a = 32'hF000_0004;
      2: a = 32'hF000_0008;
      3: a = 32'hF000_0000 | (32'($urandom_range(3, 40)) << 2);
      default: begin
        a = $urandom;
        a[31:28] = 4'($urandom_range(0, 14));
        a[9:6] = 4'h0;
      end
    endcase
    return a;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_busy",      {31'h0, busy},      32'h0);
    chk("rst_mio_ready", {31'h0, mio_ready}, 32'h0);
    chk("rst_ram_en",    {31'h0, ram_en},    32'h0);
    chk("rst_gpio",      {16'h0, gpio_out},  32'h0000_A5C3);
    chk("rst_rdata",     rdata,              32'h0);
    chk("rst_ram_addr",  {22'h0, ram_addr},  32'h0);
    chk("rst_ram_wdata", ram_wdata,          32'h0);
  endtask

  initial begin
    bit lvl, mr, mw;
    int k;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = 32'h0;
    reset = 1'b0; sw_in = 16'h0;
    drive(0, 0, 32'h0, 32'h0);
    model_reset();
    tick();
    tick();
    chk_reset_vals();
    reset = 1'b1;

    // GPIO write: low 16 bits land one edge after acceptance.
    drive(0, 1, 32'hF000_0000, 32'h1234_ABCD); tick();
    chk("t1_busy", {31'h0, busy}, 32'h1);
    drive(0, 0, 32'h0, 32'h0); tick();
    chk("t1_gpio", {16'h0, gpio_out}, 32'h0000_ABCD);
    chk("t1_ready", {31'h0, mio_ready}, 32'h1);
    tick();
    chk("t1_idle", {31'h0, busy}, 32'h0);

    // RAM write then read back with RAM_WAIT=2.
    drive(0, 1, 32'h0000_0010, 32'hDEAD_BEEF); tick();
    chk("t2_ram_en", {31'h0, ram_en}, 32'h1);
    chk("t2_ram_we", {31'h0, ram_we}, 32'h1);
    chk("t2_ram_addr", {22'h0, ram_addr}, 32'h4);
    drive(0, 0, 32'h0, 32'h0);
    repeat (4) tick();
    drive(1, 0, 32'h0000_0010, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0); tick(); tick();
    chk("t2_not_ready", {31'h0, mio_ready}, 32'h0);
    chk("t2_rdata_hold", rdata, 32'h0);
    tick();
    chk("t2_ready", {31'h0, mio_ready}, 32'h1);
    chk("t2_rdata", rdata, 32'hDEAD_BEEF);
    tick();

    // Counter load near wrap, read two cycles after the load.
    drive(0, 1, 32'hF000_0008, 32'hFFFF_FFFE); tick();
    drive(0, 0, 32'h0, 32'h0); tick(); tick();
    drive(1, 0, 32'hF000_0008, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0); tick();
    chk("t3_ready", {31'h0, mio_ready}, 32'h1);
    chk("t3_cnt_wrap", rdata, 32'h0);
    tick();

    // Pending read serviced after DONE; a third edge is dropped.
    ready_seen = 0;
    drive(1, 0, 32'h0000_0010, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0); tick();
    drive(1, 0, 32'h0000_0010, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0); tick();
    drive(0, 1, 32'hF000_0000, 32'h0000_FFFF); tick();
    drive(0, 0, 32'h0, 32'h0);
    repeat (8) tick();
    chk("t4_pulses", 32'(ready_seen), 32'd2);
    chk("t4_dropped", {16'h0, gpio_out}, 32'h0000_ABCD);
    chk("t4_idle", {31'h0, busy}, 32'h0);

    // Reset during RAM_WAIT aborts; the next request completes.
    drive(0, 1, 32'h0000_0020, 32'h1111_2222); tick();
    drive(0, 0, 32'h0, 32'h0); tick();
    reset = 1'b0; #1;
    chk_reset_vals();
    model_reset();
    tick(); tick();
    reset = 1'b1;
    drive(1, 0, 32'h0000_0020, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0);
    repeat (3) tick();
    chk("t5_ready", {31'h0, mio_ready}, 32'h1);
    chk("t5_rdata", rdata, 32'h1111_2222);
    tick();

    // Read+write together is a write; unmapped read returns zero.
    drive(1, 1, 32'hF000_0000, 32'h0000_BEEF); tick();
    drive(0, 0, 32'h0, 32'h0); tick();
    chk("t6_gpio", {16'h0, gpio_out}, 32'h0000_BEEF);
    chk("t6_rdata_hold", rdata, 32'h1111_2222);
    tick();
    drive(1, 0, 32'hF000_0100, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0); tick();
    chk("t6_ready", {31'h0, mio_ready}, 32'h1);
    chk("t6_unmapped", rdata, 32'h0);
    tick();

    lvl = 1'b0; mr = 1'b0; mw = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 40) begin
        lvl = !lvl;
        if (lvl) begin
          k = $urandom_range(0, 2);
          mr = (k != 1);
          mw = (k != 0);
        end
      end
      mem_r = lvl & mr;
      mem_w = lvl & mw;
      addr  = rand_addr();
      wdata = $urandom;
      sw_in = 16'($urandom);
      if (i == 2000) reset = 1'b0;
      if (i == 2002) reset = 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
